bin_to_bcd_digits: RTL and testbench

- Converts the unsigned binary product word of the transform multiplier back into decimal digits, using a sequential shift-and-add-3 (double-dabble) FSM.
- Inverse of the digit-to-binary path: output digits use the same digit-vector format as the multiplier's operands, with digit k (weight 10^k) at bits [4k+3:4k], so the least significant digit is the lowest nibble.
- Sits after the multiplier result register and feeds the display/checker with a valid/ready handshake on both sides.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/bcd_adj_row.sv | 15 +
 rtl/bin_to_bcd_digits.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_digits.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared digit types, FSM states and BCD helpers
package mult_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Decimal digits needed for an n-bit unsigned value: ceil(n * log10(2)).
  function automatic int clog10_pow2(input int n);
    return (n * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [DIG_W-1:0] bcd_adj(input logic [DIG_W-1:0] d);
    return (d >= DIG_W'(5)) ? d + DIG_W'(3) : d;
  endfunction

endpackage

// File: rtl/bcd_adj_row.sv
// rtl/bcd_adj_row.sv - add-3 correction applied to every digit in parallel
module bcd_adj_row
  import mult_pkg::*;
#(
  parameter int DD = 5
) (
  input  logic [DIG_W*DD-1:0] bcd_i,
  output logic [DIG_W*DD-1:0] bcd_o
);

  for (genvar k = 0; k < DD; k++) begin : g_dig
    assign bcd_o[DIG_W*k +: DIG_W] = bcd_adj(bcd_i[DIG_W*k +: DIG_W]);
  end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// rtl/bin_to_bcd_digits.sv - sequential double-dabble binary to decimal digit converter
module bin_to_bcd_digits
  import mult_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W*NDIG-1:0] bcd_out,
  output logic                  ovf
);

  localparam int DD    = clog10_pow2(IN_W);
  localparam int BW    = DIG_W * DD;
  localparam int OW    = DIG_W * NDIG;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    bcd_out_q, bcd_out_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]      bcd_adj_w;
  logic [BW+IN_W-1:0] shift_w;
  logic [BW-1:0]      bcd_next;
  logic [IN_W-1:0]    bin_next;
  logic [OW-1:0]      low_digits;
  logic               hi_nz;

  bcd_adj_row #(.DD(DD)) u_adj (
    .bcd_i(bcd_q),
    .bcd_o(bcd_adj_w)
  );

  assign shift_w  = {bcd_adj_w, bin_q} << 1;
  assign bcd_next = shift_w[BW+IN_W-1:IN_W];
  assign bin_next = shift_w[IN_W-1:0];

  // Digits beyond NDIG only feed the overflow flag; missing ones read as zero.
  if (NDIG < DD) begin : g_trunc
    assign low_digits = bcd_next[OW-1:0];
    assign hi_nz      = |bcd_next[BW-1:OW];
  end else if (NDIG == DD) begin : g_exact
    assign low_digits = bcd_next;
    assign hi_nz      = 1'b0;
  end else begin : g_pad
    assign low_digits = {{(OW-BW){1'b0}}, bcd_next};
    assign hi_nz      = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_next;
        bcd_d = bcd_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_out_d = low_digits;
          ovf_d     = hi_nz;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// tb/tb_bin_to_bcd_digits.sv - directed self-checking bench for bin_to_bcd_digits
module tb_bin_to_bcd_digits;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] bin_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bin_to_bcd_digits #(.IN_W(16), .NDIG(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bin_in(bin_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bcd_out(bcd_out),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic convert(input logic [15:0] val, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input int hold);
    int n;
    check("idle_ready", in_ready, 1);
    bin_in    = val;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick(1);
    in_valid = 1'b0;
    check("busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick(1);
      n++;
    end
    check("latency", n, 16);
    check("bcd", bcd_out, exp_bcd);
    check("ovf", ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      check("hold_bcd", bcd_out, exp_bcd);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      in_valid = ~in_valid;
      bin_in   = 16'h0007;
      tick(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("valid_pulse", out_valid, 0);
    check("ready_back", in_ready, 1);
  endtask

  logic [15:0] b2b_val[3] = '{16'h0ABC, 16'h0001, 16'h270F};
  logic [15:0] b2b_exp[3] = '{16'h2748, 16'h0001, 16'h9999};

  initial begin
    int n;
    int last;
    rst = 1'b1;
    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ovf", ovf, 0);

    bin_in   = 16'd5;
    in_valid = 1'b1;
    tick(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_wins", in_ready, 1);

    convert(16'd0,     16'h0000, 1'b0, 0);
    convert(16'd9801,  16'h9801, 1'b0, 0);
    convert(16'd9999,  16'h9999, 1'b0, 0);
    convert(16'd10000, 16'h0000, 1'b1, 0);
    convert(16'd65535, 16'h5535, 1'b1, 0);
    convert(16'd1234,  16'h1234, 1'b0, 5);

    bin_in   = 16'd4321;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_bcd", bcd_out, 0);
    check("abort_ovf", ovf, 0);
    check("abort_ready", in_ready, 1);
    convert(16'd5678, 16'h5678, 1'b0, 0);

    out_ready = 1'b1;
    bin_in    = b2b_val[0];
    in_valid  = 1'b1;
    last      = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!out_valid && n < 60) begin
        tick(1);
        n++;
      end
      check("b2b_seen", out_valid, 1);
      check("b2b_bcd", bcd_out, b2b_exp[i]);
      check("b2b_ovf", ovf, 0);
      if (i > 0) check("b2b_spacing", cyc - last, 18);
      last = cyc;
      if (i < 2) bin_in = b2b_val[i+1];
      else in_valid = 1'b0;
      tick(1);
    end
    tick(3);
    check("final_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
